// File: rtl/serv_rf_ram_resp.sv
// serv_rf_ram_resp: RAM-side responder for the SERV register-file interface.
// Holds the 1R1W register-file array. After reset it clears every word, then
// serves the core's read/write strobes. A debug port uses array cycles that
// the core leaves idle, and the core always wins.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_waddr/i_wdata    core write word address / data, strobed by i_wen
//   i_raddr/i_ren      core read word address / strobe
//   o_rdata            core read data, one cycle after i_ren
//   o_init_done        high once the clear sweep has finished
//   i_dbg_req          debug request, held high until o_dbg_ack
//   i_dbg_we           debug write(1) / read(0)
//   i_dbg_addr         debug word address
//   i_dbg_wdata        debug write data
//   o_dbg_ack          single-cycle completion pulse
//   o_dbg_rdata        debug read data, valid with o_dbg_ack on reads
module serv_rf_ram_resp #(
    parameter int unsigned width    = 8,
    parameter int unsigned csr_regs = 4,
    parameter int unsigned raw      = $clog2(32 + csr_regs),
    parameter int unsigned aw       = 5 + raw - $clog2(width),
    parameter int unsigned depth    = 32 * (32 + csr_regs) / width
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [aw-1:0]    i_dbg_addr,
    input  logic [width-1:0] i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [width-1:0] o_dbg_rdata
);

    localparam logic [1:0] INIT     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] DBG_WAIT = 2'd2;

    // One extra bit so the range check also works when depth == 2**aw.
    localparam logic [aw:0]   DEPTH_EXT = (aw + 1)'(depth);
    localparam logic [aw-1:0] LAST_WORD = aw'(depth - 1);

    logic [width-1:0] r_mem [0:depth-1];

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [aw-1:0]    r_cnt;
    logic [aw-1:0]    w_cnt_nxt;
    logic [width-1:0] r_dbg_q;

    logic             w_we;
    logic [aw-1:0]    w_wa;
    logic [width-1:0] w_wd;
    logic             w_core_rd;
    logic             w_dbg_rd_go;
    logic             w_dbg_load;
    logic             w_ack_nxt;
    logic             w_done_nxt;

    logic w_waddr_ok;
    logic w_raddr_ok;
    logic w_daddr_ok;

    assign w_waddr_ok = ({1'b0, i_waddr}    < DEPTH_EXT);
    assign w_raddr_ok = ({1'b0, i_raddr}    < DEPTH_EXT);
    assign w_daddr_ok = ({1'b0, i_dbg_addr} < DEPTH_EXT);

    // State and clear-counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, write-port mux and debug arbitration.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_wa        = i_waddr;
        w_wd        = i_wdata;
        w_core_rd   = 1'b0;
        w_dbg_rd_go = 1'b0;
        w_dbg_load  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_done_nxt  = o_init_done;
        case (r_state)
            INIT: begin
                w_we      = 1'b1;
                w_wa      = r_cnt;
                w_wd      = '0;
                w_cnt_nxt = r_cnt + aw'(1);
                if (r_cnt == LAST_WORD) begin
                    w_state_nxt = RUN;
                    w_done_nxt  = 1'b1;
                end
            end
            RUN: begin
                w_core_rd = i_ren;
                w_we      = i_wen && w_waddr_ok;
                // No grant while the previous ack is still showing.
                if (i_dbg_req && !o_dbg_ack) begin
                    if (i_dbg_we && !i_wen) begin
                        w_we      = w_daddr_ok;
                        w_wa      = i_dbg_addr;
                        w_wd      = i_dbg_wdata;
                        w_ack_nxt = 1'b1;
                    end else if (!i_dbg_we && !i_ren) begin
                        w_dbg_rd_go = 1'b1;
                        w_state_nxt = DBG_WAIT;
                    end
                end
            end
            DBG_WAIT: begin
                w_core_rd   = i_ren;
                w_we        = i_wen && w_waddr_ok;
                w_dbg_load  = 1'b1;
                w_ack_nxt   = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Array write port; contents are cleared by the INIT sweep, not by reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
    end

    // Registered outputs and the debug read staging register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata     <= '0;
            o_init_done <= 1'b0;
            o_dbg_ack   <= 1'b0;
            o_dbg_rdata <= '0;
            r_dbg_q     <= '0;
        end else begin
            o_init_done <= w_done_nxt;
            o_dbg_ack   <= w_ack_nxt;
            if (w_core_rd) begin
                o_rdata <= w_raddr_ok ? r_mem[i_raddr] : '0;
            end
            if (w_dbg_rd_go) begin
                r_dbg_q <= w_daddr_ok ? r_mem[i_dbg_addr] : '0;
            end
            if (w_dbg_load) begin
                o_dbg_rdata <= r_dbg_q;
            end
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// Directed bench for serv_rf_ram_resp at default parameters (width 8, depth 144).
module tb_serv_rf_ram_resp;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] waddr, raddr, dbg_addr;
    logic [W-1:0]  wdata, dbg_wdata;
    logic          wen, ren, dbg_req, dbg_we;
    logic [W-1:0]  rdata, dbg_rdata;
    logic          init_done, dbg_ack;

    int tests = 0;
    int fails = 0;
    int n_done;
    logic saw_ack;

    serv_rf_ram_resp dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_raddr     (raddr),
        .i_ren       (ren),
        .o_rdata     (rdata),
        .o_init_done (init_done),
        .i_dbg_req   (dbg_req),
        .i_dbg_we    (dbg_we),
        .i_dbg_addr  (dbg_addr),
        .i_dbg_wdata (dbg_wdata),
        .o_dbg_ack   (dbg_ack),
        .o_dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for o_init_done; returns cycles since call, 0 on timeout.
    task automatic wait_init(output int n);
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (dbg_ack) saw_ack = 1'b1;
            if (init_done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic core_read(input logic [AW-1:0] a);
        ren = 1'b1; raddr = a;
        step();
        ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        saw_ack = 1'b0;
        step(); step();
        check("rst_rdata", 32'(rdata), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_ack", 32'(dbg_ack), 0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 0);

        // Core and debug traffic during INIT must be ignored.
        wen = 1'b1; waddr = 8'd3; wdata = 8'hFF;
        ren = 1'b1; raddr = 8'd3;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd7; dbg_wdata = 8'h99;
        rst = 1'b0;
        wait_init(n_done);
        wen = 1'b0; ren = 1'b0; dbg_req = 1'b0;
        check("init_len", 32'(n_done), 144);
        check("init_rdata_held", 32'(rdata), 0);
        check("init_no_ack", 32'(saw_ack), 0);

        for (int a = 0; a < 144; a++) begin
            core_read(AW'(a));
            check($sformatf("clear_%0d", a), 32'(rdata), 0);
        end

        // Write then read back, with hold while i_ren is low.
        wen = 1'b1; waddr = 8'd10; wdata = 8'hA5;
        step();
        wen = 1'b0;
        core_read(8'd10);
        check("rd10", 32'(rdata), 32'hA5);
        raddr = 8'd11;
        step(); step();
        check("rd10_hold", 32'(rdata), 32'hA5);

        // Same-cycle read/write is read-first.
        wen = 1'b1; waddr = 8'd20; wdata = 8'h11;
        step();
        wdata = 8'h3C; ren = 1'b1; raddr = 8'd20;
        step();
        wen = 1'b0;
        check("rw_same_old", 32'(rdata), 32'h11);
        step();
        ren = 1'b0;
        check("rw_same_new", 32'(rdata), 32'h3C);

        // Debug read blocked by core reads, then served two cycles after.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd10;
        ren = 1'b1; raddr = 8'd20;
        saw_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (dbg_ack) saw_ack = 1'b1;
        end
        check("dbgrd_blocked", 32'(saw_ack), 0);
        ren = 1'b0;
        step();
        check("dbgrd_wait", 32'(dbg_ack), 0);
        step();
        check("dbgrd_ack", 32'(dbg_ack), 1);
        check("dbgrd_data", 32'(dbg_rdata), 32'hA5);
        check("dbgrd_rdata_kept", 32'(rdata), 32'h3C);
        dbg_req = 1'b0;
        step();
        check("dbgrd_ack_pulse", 32'(dbg_ack), 0);

        // Out-of-range debug write acks and is dropped; req held through ack.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd200; dbg_wdata = 8'h77;
        step();
        check("dbgwr_oor_ack", 32'(dbg_ack), 1);
        step();
        check("dbgwr_no_regrant", 32'(dbg_ack), 0);
        dbg_we = 1'b0;
        step();
        step();
        check("dbgrd_oor_ack", 32'(dbg_ack), 1);
        check("dbgrd_oor_data", 32'(dbg_rdata), 0);
        dbg_req = 1'b0;
        core_read(8'd56);
        check("oor_alias56", 32'(rdata), 0);
        core_read(8'd72);
        check("oor_alias72", 32'(rdata), 0);

        // Out-of-range core write dropped, core read returns 0.
        wen = 1'b1; waddr = 8'd250; wdata = 8'h55;
        step();
        wen = 1'b0;
        core_read(8'd250);
        check("core_oor_rd", 32'(rdata), 0);
        core_read(8'd122);
        check("core_oor_alias", 32'(rdata), 0);

        // Debug write vs core read on the same word is read-first.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd30; dbg_wdata = 8'h5A;
        ren = 1'b1; raddr = 8'd30;
        step();
        dbg_req = 1'b0;
        check("dbgwr_rf_old", 32'(rdata), 0);
        check("dbgwr_rf_ack", 32'(dbg_ack), 1);
        step();
        ren = 1'b0;
        check("dbgwr_rf_new", 32'(rdata), 32'h5A);

        // Core writes hold off a debug write.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd40; dbg_wdata = 8'h42;
        wen = 1'b1; waddr = 8'd41; wdata = 8'h24;
        saw_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (dbg_ack) saw_ack = 1'b1;
        end
        check("dbgwr_blocked", 32'(saw_ack), 0);
        wen = 1'b0;
        step();
        check("dbgwr_late_ack", 32'(dbg_ack), 1);
        dbg_req = 1'b0;
        core_read(8'd40);
        check("rd40", 32'(rdata), 32'h42);
        core_read(8'd41);
        check("rd41", 32'(rdata), 32'h24);

        // Reset during DBG_WAIT aborts the ack and restarts the sweep.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd10;
        step();
        rst = 1'b1;
        #1;
        dbg_req = 1'b0;
        check("rstmid_ack", 32'(dbg_ack), 0);
        check("rstmid_done", 32'(init_done), 0);
        step();
        check("rstmid_ack2", 32'(dbg_ack), 0);
        saw_ack = 1'b0;
        rst = 1'b0;
        wait_init(n_done);
        check("reinit_len", 32'(n_done), 144);
        check("reinit_no_ack", 32'(saw_ack), 0);
        core_read(8'd10);
        check("reinit_rd10", 32'(rdata), 0);
        core_read(8'd41);
        check("reinit_rd41", 32'(rdata), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
